// File: rtl/rop_dcr_readback_if.sv
// rop_dcr_readback_if: request/response handshake bundle for the ROP DCR read-back responder.
// Optional rsp_parity exists only when ROP_DCR_READBACK_PARITY_EN is defined.
interface rop_dcr_readback_if #(
    parameter int WADDR_BITS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_burst;
    logic [WADDR_BITS-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [WADDR_BITS-1:0] rsp_addr;
    logic                  rsp_last;
    logic                  rsp_err;
`ifdef ROP_DCR_READBACK_PARITY_EN
    logic                  rsp_parity;
`endif

    modport slave (
        input  req_valid, req_burst, req_addr, rsp_ready,
`ifdef ROP_DCR_READBACK_PARITY_EN
        output rsp_parity,
`endif
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );

    modport master (
        output req_valid, req_burst, req_addr, rsp_ready,
`ifdef ROP_DCR_READBACK_PARITY_EN
        input  rsp_parity,
`endif
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );
endinterface

// File: rtl/rop_dcr_readback.sv
// rop_dcr_readback: word-addressed single/burst read-back of a snapshotted flat DCR state vector.
// Define ROP_DCR_READBACK_PARITY_EN to add the even-parity rsp_parity output.
module rop_dcr_readback #(
    parameter int DCRS_BITS  = 416,
    parameter int NUM_WORDS  = (DCRS_BITS + 31) / 32,
    parameter int WADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DCRS_BITS-1:0] dcrs_in,
    rop_dcr_readback_if.slave    bus,
    output logic                 busy
);
    localparam logic [WADDR_BITS-1:0] LAST = WADDR_BITS'(NUM_WORDS - 1);
    localparam logic [WADDR_BITS:0]   NW   = (WADDR_BITS + 1)'(NUM_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                       state_q, state_d;
    logic [WADDR_BITS-1:0]        ptr_q, ptr_d;
    logic [NUM_WORDS-1:0][31:0]   snap_q, snap_d, din_w;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [31:0]                  rsp_data_q, rsp_data_d;
    logic [WADDR_BITS-1:0]        rsp_addr_q, rsp_addr_d;
    logic                         rsp_last_q, rsp_last_d;
    logic                         rsp_err_q, rsp_err_d;
    logic                         req_rdy, err;

    // zero-pads the top word when DCRS_BITS is not a multiple of 32
    assign din_w = (NUM_WORDS * 32)'(dcrs_in);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        snap_d      = snap_q;
        rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        req_rdy     = state_q == IDLE && (!rsp_valid_q || bus.rsp_ready);
        err         = {1'b0, bus.req_addr} >= NW;
        if (state_q == IDLE) begin
            if (bus.req_valid && req_rdy) begin
                snap_d      = din_w;
                rsp_valid_d = 1'b1;
                rsp_data_d  = err ? '0 : din_w[bus.req_addr];
                rsp_addr_d  = bus.req_addr;
                rsp_err_d   = err;
                rsp_last_d  = err || !bus.req_burst || bus.req_addr == LAST;
                state_d     = rsp_last_d ? IDLE : BURST;
                ptr_d       = bus.req_addr + 1'b1;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = snap_q[ptr_q];
            rsp_addr_d  = ptr_q;
            rsp_err_d   = 1'b0;
            rsp_last_d  = ptr_q == LAST;
            state_d     = rsp_last_d ? IDLE : BURST;
            ptr_d       = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            snap_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef ROP_DCR_READBACK_PARITY_EN
    logic rsp_parity_q;

    // error responses carry zero data, so their parity is naturally 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rsp_parity_q <= 1'b0;
        else        rsp_parity_q <= ^rsp_data_d;
    end

    assign bus.rsp_parity = rsp_parity_q;
`endif

    assign bus.req_ready = req_rdy;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = state_q != IDLE || rsp_valid_q;
endmodule

// File: tb/tb_rop_dcr_readback.sv
// tb_rop_dcr_readback: directed checks of single/burst read-back, snapshot, backpressure, errors, padding and async reset.
module tb_rop_dcr_readback;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [415:0] dcrs;
    logic         busy, busy2;
    int           n_chk = 0;
    int           n_pass = 0;

    rop_dcr_readback_if #(.WADDR_BITS(4)) bus ();
    rop_dcr_readback_if #(.WADDR_BITS(4)) bus2 ();

    rop_dcr_readback #(.DCRS_BITS(416)) dut (
        .clk(clk), .reset(reset), .dcrs_in(dcrs), .bus(bus), .busy(busy)
    );

    rop_dcr_readback #(.DCRS_BITS(400)) dut2 (
        .clk(clk), .reset(reset), .dcrs_in(dcrs[399:0]), .bus(bus2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expw(input int k);
        return k == 2 ? 32'hDEADBEEF : k == 7 ? 32'h00000007 : k == 11 ? 32'h11111111 : 32'hC0DE0000 + k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic b, input logic [3:0] a);
        bus.req_valid = 1'b1;
        bus.req_burst = b;
        bus.req_addr  = a;
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        cyc();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 13; i++) dcrs[i*32 +: 32] = expw(i);
        bus.req_valid  = 1'b0;
        bus.req_burst  = 1'b0;
        bus.req_addr   = '0;
        bus.rsp_ready  = 1'b1;
        bus2.req_valid = 1'b0;
        bus2.req_burst = 1'b0;
        bus2.req_addr  = '0;
        bus2.rsp_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_last", 32'(bus.rsp_last), 0);
        reset = 1'b1;
        cyc();

        req(1'b0, 4'd2);
        chk("s_valid", 32'(bus.rsp_valid), 1);
        chk("s_data", bus.rsp_data, 32'hDEADBEEF);
        chk("s_addr", 32'(bus.rsp_addr), 2);
        chk("s_last", 32'(bus.rsp_last), 1);
        chk("s_err", 32'(bus.rsp_err), 0);
        chk("s_busy", 32'(busy), 1);
        cyc();
        chk("s_done_valid", 32'(bus.rsp_valid), 0);
        chk("s_done_busy", 32'(busy), 0);

        req(1'b1, 4'd0);
        for (int k = 0; k < 13; k++) begin
            chk("b_valid", 32'(bus.rsp_valid), 1);
            chk("b_addr", 32'(bus.rsp_addr), k);
            chk("b_data", bus.rsp_data, expw(k));
            chk("b_last", 32'(bus.rsp_last), k == 12 ? 1 : 0);
            chk("b_req_ready", 32'(bus.req_ready), k == 12 ? 1 : 0);
            cyc();
        end
        chk("b_busy_drop", 32'(busy), 0);
        chk("b_valid_drop", 32'(bus.rsp_valid), 0);

        req(1'b1, 4'd10);
        dcrs[11*32 +: 32] = 32'h22222222;
        chk("snap_w10", bus.rsp_data, expw(10));
        cyc();
        chk("snap_w11", bus.rsp_data, 32'h11111111);
        cyc();
        chk("snap_w12", bus.rsp_data, expw(12));
        chk("snap_last", 32'(bus.rsp_last), 1);
        cyc();

        bus.rsp_ready = 1'b0;
        req(1'b1, 4'd11);
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", bus.rsp_data, 32'h22222222);
            chk("bp_addr", 32'(bus.rsp_addr), 11);
            chk("bp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_req_ready", 32'(bus.req_ready), 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_rel_addr", 32'(bus.rsp_addr), 11);
        cyc();
        chk("bp_w12_addr", 32'(bus.rsp_addr), 12);
        chk("bp_w12_data", bus.rsp_data, expw(12));
        chk("bp_w12_last", 32'(bus.rsp_last), 1);
        cyc();
        chk("bp_end_valid", 32'(bus.rsp_valid), 0);

        req(1'b0, 4'd13);
        chk("e13_err", 32'(bus.rsp_err), 1);
        chk("e13_data", bus.rsp_data, 0);
        chk("e13_last", 32'(bus.rsp_last), 1);
        chk("e13_addr", 32'(bus.rsp_addr), 13);
        cyc();
        chk("e13_once", 32'(bus.rsp_valid), 0);
        req(1'b1, 4'd15);
        chk("e15_err", 32'(bus.rsp_err), 1);
        chk("e15_data", bus.rsp_data, 0);
        chk("e15_last", 32'(bus.rsp_last), 1);
        chk("e15_addr", 32'(bus.rsp_addr), 15);
        cyc();
        chk("e15_once", 32'(bus.rsp_valid), 0);
        chk("e15_busy", 32'(busy), 0);

        bus.req_valid = 1'b1;
        bus.req_burst = 1'b0;
        bus.req_addr  = 4'd3;
        cyc();
        chk("bb_w3", bus.rsp_data, expw(3));
        bus.req_addr = 4'd4;
        chk("bb_req_ready", 32'(bus.req_ready), 1);
        cyc();
        bus.req_valid = 1'b0;
        chk("bb_w4", bus.rsp_data, expw(4));
        chk("bb_w4_addr", 32'(bus.rsp_addr), 4);
        cyc();
        chk("bb_end", 32'(bus.rsp_valid), 0);

        bus2.req_valid = 1'b1;
        bus2.req_addr  = 4'd12;
        cyc();
        bus2.req_valid = 1'b0;
        chk("pad_w12", bus2.rsp_data, 32'h0000000C);
        chk("pad_last", 32'(bus2.rsp_last), 1);
        cyc();

`ifdef ROP_DCR_READBACK_PARITY_EN
        req(1'b0, 4'd7);
        chk("par_w7", 32'(bus.rsp_parity), 1);
        cyc();
        req(1'b0, 4'd2);
        chk("par_w2", 32'(bus.rsp_parity), 0);
        cyc();
`endif

        req(1'b1, 4'd0);
        repeat (5) cyc();
        chk("ar_pre_addr", 32'(bus.rsp_addr), 5);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.rsp_valid), 0);
        chk("ar_data", bus.rsp_data, 0);
        chk("ar_addr", 32'(bus.rsp_addr), 0);
        chk("ar_last", 32'(bus.rsp_last), 0);
        chk("ar_busy", 32'(busy), 0);
        repeat (2) cyc();
        reset = 1'b1;
        repeat (3) cyc();
        chk("ar_post_valid", 32'(bus.rsp_valid), 0);
        chk("ar_post_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
